// File: rtl/cp0_regfile_pkg.sv
// ============================================================================
// Module      : cp0_regfile_pkg
// Description : Shared CP0 constants: register addresses, exception codes,
//               exception vector and the Status software-visible fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_regfile_pkg;

  // CP0 register addresses as {sel, rd}; all live at sel 0
  localparam logic [7:0] CR_BADVADDR = 8'd8;
  localparam logic [7:0] CR_COUNT    = 8'd9;
  localparam logic [7:0] CR_COMPARE  = 8'd11;
  localparam logic [7:0] CR_STATUS   = 8'd12;
  localparam logic [7:0] CR_CAUSE    = 8'd13;
  localparam logic [7:0] CR_EPC      = 8'd14;

  // Exception codes
  localparam logic [4:0] EX_INT  = 5'd0;
  localparam logic [4:0] EX_ADEL = 5'd4;
  localparam logic [4:0] EX_ADES = 5'd5;
  localparam logic [4:0] EX_SYS  = 5'd8;
  localparam logic [4:0] EX_BP   = 5'd9;
  localparam logic [4:0] EX_RI   = 5'd10;
  localparam logic [4:0] EX_OV   = 5'd12;

  // Exception entry point (BEV=1)
  localparam logic [31:0] EX_VECTOR = 32'hBFC0_0380;

  // Writable part of Status
  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  // Address-error exceptions are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EX_ADEL) || (code == EX_ADES);
  endfunction

  // True for exception codes the core is able to raise
  function automatic logic exc_known(input logic [4:0] code);
    return (code == EX_INT) || (code == EX_ADEL) || (code == EX_ADES) ||
           (code == EX_SYS) || (code == EX_BP)   || (code == EX_RI)   ||
           (code == EX_OV);
  endfunction

  // Target address used by the fetch stage on exception entry
  function automatic logic [31:0] exc_target();
    return EX_VECTOR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_regfile_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer with programmable pre-divider and an
//               edge-qualified timer interrupt flag (TI).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int              c_div_w   = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(COUNT_DIV - 1);

  logic [c_div_w-1:0] r_div;
  logic [31:0]        r_count;
  logic [31:0]        r_compare;
  logic               r_ti;
  logic               w_tick;
  logic [31:0]        w_count_inc;

  // A Count write restarts the divider, so its own tick is discarded
  assign w_tick      = (r_div == c_div_max) && !count_we;
  assign w_count_inc = r_count + 32'd1;

  // Pre-divider: free-running 0..COUNT_DIV-1, restarted by a Count write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_div <= '0;
    else if (count_we || (r_div == c_div_max))
      r_div <= '0;
    else
      r_div <= r_div + c_div_w'(1);
  end

  // Count: software load has priority over the tick increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_count <= '0;
    else if (count_we)
      r_count <= wdata;
    else if (w_tick)
      r_count <= w_count_inc;
  end

  // Compare register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_compare <= '0;
    else if (compare_we)
      r_compare <= wdata;
  end

  // TI sets only when Count steps onto Compare; a Compare write clears it and wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_ti <= 1'b0;
    else if (compare_we)
      r_ti <= 1'b0;
    else if (w_tick && (w_count_inc == r_compare))
      r_ti <= 1'b1;
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_regfile.sv
// ============================================================================
// Module      : cp0_regfile
// Description : CP0 register file (Status, Cause, EPC, Count, Compare,
//               BadVAddr) committing exception/ERET/MTC0 effects in WB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int N_EXT_INT = 6,
  parameter int COUNT_DIV = 2,
  parameter int TI_IP     = 7
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wb_valid,
  input  logic                 wb_op_mtc0,
  input  logic                 wb_op_eret,
  input  logic                 wb_ex,
  input  logic                 wb_bd,
  input  logic [4:0]           wb_excode,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_badvaddr,
  input  logic [7:0]           c0_addr,
  input  logic [31:0]          c0_wdata,
  output logic [31:0]          c0_rdata,
  output logic [31:0]          epc_out,
  input  logic [N_EXT_INT-1:0] ext_int_in,
  output logic                 has_int
);

  // One-hot position of the timer line within IP[7:2]
  localparam logic [5:0] c_ti_mask = 6'(1) << (TI_IP - 2);

  status_t     r_status;
  logic        r_bd;
  logic [4:0]  r_excode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_ip_hw;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_mtc0_we;
  logic        w_eret;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic [5:0]  w_ext_pad;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [31:0] w_status_rd;
  logic [31:0] w_cause_rd;
  logic [7:0]  w_ip;

  // An excepting instruction commits nothing else
  assign w_mtc0_we    = wb_valid & wb_op_mtc0 & ~wb_ex;
  assign w_eret       = wb_valid & wb_op_eret & ~wb_ex;
  assign w_wr_status  = w_mtc0_we && (c0_addr == CR_STATUS);
  assign w_wr_cause   = w_mtc0_we && (c0_addr == CR_CAUSE);
  assign w_wr_epc     = w_mtc0_we && (c0_addr == CR_EPC);
  assign w_wr_count   = w_mtc0_we && (c0_addr == CR_COUNT);
  assign w_wr_compare = w_mtc0_we && (c0_addr == CR_COMPARE);

  generate
    if (N_EXT_INT < 6) begin : g_ext_pad
      assign w_ext_pad = {{(6 - N_EXT_INT){1'b0}}, ext_int_in};
    end else begin : g_ext_full
      assign w_ext_pad = ext_int_in[5:0];
    end
  endgenerate

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (w_wr_count),
    .compare_we (w_wr_compare),
    .wdata      (c0_wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  // Status: exception entry beats ERET, which beats an MTC0 write of EXL
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status <= '0;
    end else begin
      if (w_wr_status) begin
        r_status.im <= c0_wdata[15:8];
        r_status.ie <= c0_wdata[0];
      end
      if (wb_ex)
        r_status.exl <= 1'b1;
      else if (w_eret)
        r_status.exl <= 1'b0;
      else if (w_wr_status)
        r_status.exl <= c0_wdata[1];
    end
  end

  // Cause: BD frozen inside a handler, ExcCode always tracks the latest exception
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bd     <= 1'b0;
      r_excode <= '0;
      r_ip_sw  <= '0;
      r_ip_hw  <= '0;
    end else begin
      if (wb_ex && !r_status.exl)
        r_bd <= wb_bd;
      if (wb_ex)
        r_excode <= wb_excode;
      if (w_wr_cause)
        r_ip_sw <= c0_wdata[9:8];
      r_ip_hw <= w_ext_pad | (w_ti ? c_ti_mask : 6'b0);
    end
  end

  // EPC: restart address on first-level exception, else software writable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_epc <= '0;
    else if (wb_ex && !r_status.exl)
      r_epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
    else if (w_wr_epc)
      r_epc <= c0_wdata;
  end

  // BadVAddr: captured on address errors only, never written by software
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_badvaddr <= '0;
    else if (wb_ex && is_addr_exc(wb_excode))
      r_badvaddr <= wb_badvaddr;
  end

  assign w_ip        = {r_ip_hw, r_ip_sw};
  assign w_status_rd = {9'b0, 1'b1, 6'b0, r_status.im, 6'b0, r_status.exl, r_status.ie};
  assign w_cause_rd  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_excode, 2'b0};

  // MFC0 read port: unmapped or non-zero sel reads as zero
  always_comb begin
    c0_rdata = 32'b0;
    case (c0_addr)
      CR_BADVADDR: c0_rdata = r_badvaddr;
      CR_COUNT:    c0_rdata = w_count;
      CR_COMPARE:  c0_rdata = w_compare;
      CR_STATUS:   c0_rdata = w_status_rd;
      CR_CAUSE:    c0_rdata = w_cause_rd;
      CR_EPC:      c0_rdata = r_epc;
      default:     c0_rdata = 32'b0;
    endcase
  end

  assign epc_out = r_epc;
  assign has_int = (|(w_ip & r_status.im)) & r_status.ie & ~r_status.exl;

endmodule

`default_nettype wire

// File: tb/tb_cp0_regfile.sv
// ============================================================================
// Module      : tb_cp0_regfile
// Description : Self-checking bench for cp0_regfile; instance A uses the
//               default parameters, instance B uses COUNT_DIV=1, N_EXT_INT=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_regfile;

  localparam logic [7:0] A_BVA = 8'd8;
  localparam logic [7:0] A_CNT = 8'd9;
  localparam logic [7:0] A_CMP = 8'd11;
  localparam logic [7:0] A_ST  = 8'd12;
  localparam logic [7:0] A_CA  = 8'd13;
  localparam logic [7:0] A_EPC = 8'd14;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        wb_valid, wb_op_mtc0, wb_op_eret, wb_ex, wb_bd;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, c0_wdata;
  logic [7:0]  c0_addr;
  logic [5:0]  ext;
  logic [31:0] rdata_a, epc_a, rdata_b, epc_b;
  logic        hi_a, hi_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cp0_regfile dut_a (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_op_mtc0(wb_op_mtc0),
    .wb_op_eret(wb_op_eret), .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_excode(wb_excode),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(rdata_a), .epc_out(epc_a), .ext_int_in(ext), .has_int(hi_a)
  );

  cp0_regfile #(.N_EXT_INT(2), .COUNT_DIV(1), .TI_IP(7)) dut_b (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_op_mtc0(wb_op_mtc0),
    .wb_op_eret(wb_op_eret), .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_excode(wb_excode),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(rdata_b), .epc_out(epc_b), .ext_int_in(ext[1:0]), .has_int(hi_b)
  );

  typedef struct {
    logic        v, m, e, x, bd;
    logic [4:0]  code;
    logic [31:0] pc, bva;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [7:0]  raddr;
    logic [31:0] exp_rd, exp_epc;
    logic        exp_hi;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic e, input logic x,
                       input logic bd, input logic [4:0] code, input logic [31:0] pc,
                       input logic [31:0] bva, input logic [7:0] addr, input logic [31:0] wd);
    wb_valid = v; wb_op_mtc0 = m; wb_op_eret = e; wb_ex = x; wb_bd = bd;
    wb_excode = code; wb_pc = pc; wb_badvaddr = bva; c0_addr = addr; c0_wdata = wd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 8'd0, 32'd0);
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] wd);
    drive(1, 1, 0, 0, 0, 5'd0, 32'd0, 32'd0, addr, wd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] addr);
    c0_addr = addr;
    #1;
  endtask

  // Async reset: state must clear before any clock edge arrives
  task automatic do_reset();
    @(posedge clk);
    #1;
    idle();
    resetn = 1'b0;
    #1;
    rd(A_ST);
    chk("rst_status", rdata_a, 32'h0040_0000);
    chk("rst_epc", epc_a, 32'h0);
    chk("rst_hasint", {31'b0, hi_a}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    ext = 6'b0;
    idle();

    //                v  m  e  x bd code pc            bva           addr   wd             raddr   exp_rd         exp_epc        hi
    tbl[0]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         A_ST,   32'h0040_0000, 32'h0,         0};
    tbl[1]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         A_CA,   32'h0,         32'h0,         0};
    tbl[2]  = '{1, 0, 0, 1, 1, 5'd4,  32'hBFC0_0104, 32'h1233,     8'd0,  32'h0,         A_EPC,  32'hBFC0_0100, 32'hBFC0_0100, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         A_CA,   32'h8000_0010, 32'hBFC0_0100, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         A_BVA,  32'h1233,      32'hBFC0_0100, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         A_ST,   32'h0040_0002, 32'hBFC0_0100, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 5'd8,  32'h8000_0000, 32'h5555,     8'd0,  32'h0,         A_CA,   32'h8000_0020, 32'hBFC0_0100, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         A_BVA,  32'h1233,      32'hBFC0_0100, 0};
    tbl[8]  = '{1, 0, 1, 1, 0, 5'd10, 32'h0,         32'h0,        8'd0,  32'h0,         A_ST,   32'h0040_0002, 32'hBFC0_0100, 0};
    tbl[9]  = '{1, 1, 0, 1, 0, 5'd12, 32'h0,         32'h0,        A_EPC, 32'h1234,      A_EPC,  32'hBFC0_0100, 32'hBFC0_0100, 0};
    tbl[10] = '{1, 0, 1, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         A_ST,   32'h0040_0000, 32'hBFC0_0100, 0};
    tbl[11] = '{1, 1, 0, 0, 0, 5'd0,  32'h0,         32'h0,        A_EPC, 32'h1234,      A_EPC,  32'h1234,      32'h1234,      0};
    tbl[12] = '{1, 1, 0, 0, 0, 5'd0,  32'h0,         32'h0,        A_ST,  32'hFFFF_FFFF, A_ST,   32'h0040_FF03, 32'h1234,      0};
    tbl[13] = '{1, 1, 0, 0, 0, 5'd0,  32'h0,         32'h0,        A_ST,  32'h0000_0301, A_ST,   32'h0040_0301, 32'h1234,      0};
    tbl[14] = '{1, 1, 0, 0, 0, 5'd0,  32'h0,         32'h0,        A_CA,  32'h0000_0100, A_CA,   32'h8000_0130, 32'h1234,      1};
    tbl[15] = '{1, 1, 0, 0, 0, 5'd0,  32'h0,         32'h0,        A_BVA, 32'h0,         A_BVA,  32'h1233,      32'h1234,      1};
    tbl[16] = '{1, 1, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd15, 32'hFFFF,      8'd15,  32'h0,         32'h1234,      1};
    tbl[17] = '{1, 0, 0, 1, 0, 5'd5,  32'h0000_0400, 32'hDEAD,     8'd0,  32'h0,         A_BVA,  32'hDEAD,      32'h400,       0};
    tbl[18] = '{1, 1, 1, 0, 0, 5'd0,  32'h0,         32'h0,        A_ST,  32'h0000_0303, A_ST,   32'h0040_0301, 32'h400,       1};
    tbl[19] = '{0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         8'h2C,  32'h0,         32'h400,       1};
    tbl[20] = '{0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        8'd0,  32'h0,         A_CA,   32'h0000_0114, 32'h400,       1};

    // Count after reset release: A divides by 2, B counts every cycle
    do_reset();
    rd(A_CNT);
    step();
    step();
    chk("cnt2_a", rdata_a, 32'd1);
    chk("cnt2_b", rdata_b, 32'd2);
    repeat (8) step();
    chk("cnt10_a", rdata_a, 32'd5);
    chk("cnt10_b", rdata_b, 32'd10);
    rd(A_CA);
    chk("ti_idle_a", rdata_a, 32'h0);

    // Exception / ERET / MTC0 table on instance A
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].m, tbl[i].e, tbl[i].x, tbl[i].bd, tbl[i].code,
            tbl[i].pc, tbl[i].bva, tbl[i].addr, tbl[i].wd);
      step();
      idle();
      rd(tbl[i].raddr);
      chk($sformatf("vec%0d_rd", i), rdata_a, tbl[i].exp_rd);
      chk($sformatf("vec%0d_epc", i), epc_a, tbl[i].exp_epc);
      chk($sformatf("vec%0d_hi", i), {31'b0, hi_a}, {31'b0, tbl[i].exp_hi});
    end

    // MFC0 alongside MTC0 to the same register sees the old value
    mtc0(A_EPC, 32'h9999);
    #1;
    chk("rw_same_old", rdata_a, 32'h400);
    step();
    idle();
    rd(A_EPC);
    chk("rw_same_new", rdata_a, 32'h9999);

    // Count wrap: A needs two cycles after the write (divider restarted)
    do_reset();
    mtc0(A_CNT, 32'hFFFF_FFFF);
    step();
    idle();
    rd(A_CNT);
    chk("wrap0_a", rdata_a, 32'hFFFF_FFFF);
    chk("wrap0_b", rdata_b, 32'hFFFF_FFFF);
    step();
    chk("wrap1_a", rdata_a, 32'hFFFF_FFFF);
    chk("wrap1_b", rdata_b, 32'h0);
    rd(A_CA);
    chk("wrap_ti_b", rdata_b, 32'h4000_0000);
    chk("wrap_noti_a", rdata_a, 32'h0);
    step();
    rd(A_CNT);
    chk("wrap2_a", rdata_a, 32'h0);
    rd(A_CA);
    chk("wrap_ti_a", rdata_a, 32'h4000_0000);

    // Compare timer on instance B
    do_reset();
    mtc0(A_CNT, 32'd0);
    step();
    mtc0(A_ST, 32'h8001);
    step();
    mtc0(A_CMP, 32'd3);
    step();
    idle();
    rd(A_CNT);
    chk("tmr_cnt2", rdata_b, 32'd2);
    rd(A_CA);
    chk("tmr_ti_pre", rdata_b, 32'h0);
    step();
    chk("tmr_ti_set", rdata_b, 32'h4000_0000);
    chk("tmr_hi_pre", {31'b0, hi_b}, 32'h0);
    step();
    chk("tmr_ip7", rdata_b, 32'h4000_8000);
    chk("tmr_hi", {31'b0, hi_b}, 32'h1);
    mtc0(A_CMP, 32'h100);
    step();
    idle();
    rd(A_CA);
    chk("tmr_ti_clr", rdata_b, 32'h0000_8000);
    step();
    chk("tmr_ip7_clr", rdata_b, 32'h0);
    chk("tmr_hi_clr", {31'b0, hi_b}, 32'h0);
    mtc0(A_CNT, 32'h10);
    step();
    mtc0(A_CMP, 32'h12);
    step();
    mtc0(A_CMP, 32'h12);
    step();
    idle();
    rd(A_CA);
    chk("tmr_clr_wins", rdata_b, 32'h0);
    rd(A_CNT);
    chk("tmr_cnt12", rdata_b, 32'h12);
    step();
    rd(A_CA);
    chk("tmr_static_eq", rdata_b, 32'h0);

    // External and software interrupts
    do_reset();
    mtc0(A_ST, 32'h0801);
    ext = 6'b000010;
    #1;
    chk("ext_hi_pre", {31'b0, hi_b}, 32'h0);
    step();
    idle();
    rd(A_CA);
    chk("ext_ip_b", rdata_b, 32'h0000_0800);
    chk("ext_ip_a", rdata_a, 32'h0000_0800);
    chk("ext_hi_b", {31'b0, hi_b}, 32'h1);
    rd(A_ST);
    chk("ext_status_b", rdata_b, 32'h0040_0801);
    mtc0(A_CA, 32'h100);
    step();
    idle();
    rd(A_CA);
    chk("sw_ip0_b", rdata_b, 32'h0000_0900);
    ext = 6'b0;
    step();
    chk("ext_drop_b", rdata_b, 32'h0000_0100);
    chk("ext_drop_hi", {31'b0, hi_b}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cp0_regfile.md
# cp0_regfile

Parametrised CP0 register file for the five-stage MIPS core, instantiated in the WB stage. It holds Status, Cause, EPC, Count, Compare and BadVAddr, and commits exception, ERET and MTC0 side effects. It provides the combinational MFC0 read port and the ERET target, and raises `has_int` for the interrupt-sampling logic. Against the previous generation it adds:

- a configurable Count divider;
- a configurable external-interrupt count and timer IP line;
- edge-qualified timer interrupt;
- gated ERET;
- a dedicated EPC output.

## Interface
Parameters:
- `N_EXT_INT`, default 6: number of hardware interrupt inputs (1..6), mapped to IP[2+i].
- `COUNT_DIV`, default 2: Count increments once every `COUNT_DIV` cycles (≥1).
- `TI_IP`, default 7: IP bit (2..7) that the timer interrupt ORs into.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: WB holds a valid instruction.
- `wb_op_mtc0` in 1: the WB instruction is MTC0.
- `wb_op_eret` in 1: the WB instruction is ERET.
- `wb_ex` in 1: the WB instruction raises an exception; already qualified by valid.
- `wb_bd` in 1: the WB instruction sits in a branch delay slot.
- `wb_excode` in 5: exception code.
- `wb_pc` in 32: PC of the WB instruction.
- `wb_badvaddr` in 32: faulting address.
- `c0_addr` in 8: {sel, rd}.
- `c0_wdata` in 32: MTC0 data.
- `c0_rdata` out 32: MFC0 data, combinational.
- `epc_out` out 32: current EPC, the ERET target.
- `ext_int_in` in `N_EXT_INT`: level interrupt requests.
- `has_int` out 1: interrupt pending and enabled.

## Operation
Qualified events:
- mtc0_we = wb_valid & wb_op_mtc0 & ~wb_ex.
- eret = wb_valid & wb_op_eret & ~wb_ex.

Addresses, all with sel=0:
- BadVAddr 8
- Count 9
- Compare 11
- Status 12
- Cause 13
- EPC 14

Unmapped addresses read 0 and ignore writes.

Status = {9'b0, BEV=1, 6'b0, IM[7:0], 6'b0, EXL, IE}:
- IM and IE are written by MTC0.
- EXL update priority: wb_ex sets it > eret clears it > MTC0 writes it.

Cause = {BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode, 2'b0}:
- BD is loaded from `wb_bd` on wb_ex only when EXL=0.
- ExcCode is loaded on every wb_ex.
- IP[1:0] are software-written by MTC0.
- IP[7:2] are registered each cycle from `ext_int_in`, zero-extended to 6 bits.
- IP[TI_IP] additionally ORs in TI.

EPC:
- On wb_ex with EXL=0, EPC loads `wb_bd ? wb_pc-4 : wb_pc`.
- Otherwise MTC0 writes it.

BadVAddr:
- Loads `wb_badvaddr` on wb_ex when ExcCode is AdEL (4) or AdES (5).
- Read-only to MTC0.

Count:
- A divider counter runs 0..COUNT_DIV-1; tick = (div == COUNT_DIV-1).
- Count increments on tick and wraps 0xFFFFFFFF→0.
- An MTC0 write to Count loads Count, clears the divider and suppresses that cycle's tick.

Compare:
- Written by MTC0.
- An MTC0 write to Compare clears TI.

TI:
- Sets on a tick where Count+1 == Compare, i.e. only when Count increments onto Compare, never by static equality.
- If a Compare write and a TI set condition occur in the same cycle, the clear wins.

`has_int` = |(IP & IM) & IE & ~EXL.

## Timing
- Reset values: all registers 0 except Status.BEV=1; divider 0. Outputs after reset: `c0_rdata` per address, `epc_out`=0, `has_int`=0.
- Reads are combinational. MFC0 and MTC0 to the same register in the same cycle return the old value.
- Writes and exception updates are visible the cycle after the edge.
- External interrupts reach IP after one cycle and reach `has_int` in that same cycle.
- TI sets at the edge where Count becomes Compare. `has_int` is visible the following cycle.
- wb_ex and eret in the same cycle: eret is masked by wb_ex.
- Nested exception (EXL=1): EPC and BD are held; ExcCode and BadVAddr are still updated.
- `resetn` asserted mid-operation clears state immediately, independent of `clk`.

## Structure
- Constants belong in `mycpu.h`:
  - CR_* addresses;
  - EX_* codes (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12);
  - exception vector 0xBFC00380.
- Sub-module `cp0_timer`: owns divider, Count, Compare and TI. Inputs are the write strobes; outputs are Count, Compare and TI.
- Estimated size is about 250 lines of RTL.

## Test plan
- Reset release, COUNT_DIV=2:
  - Status reads 0x0040_0000.
  - Count reads 1 after 2 cycles and 5 after 10 cycles.
  - TI stays 0 while Compare=0 until Count wraps.
- Compare timer:
  - MTC0 Compare=3, COUNT_DIV=1, Status=0x8001 (IM7=1, IE=1).
  - TI sets when Count becomes 3; `has_int`=1 one cycle later.
  - MTC0 Compare=0x100 clears TI and drops `has_int`.
- Exception in a delay slot:
  - wb_ex, bd=1, pc=0xBFC0_0104, excode=4, badvaddr=0x1233.
  - Results: EPC=0xBFC0_0100, Cause=0x8000_0010, BadVAddr=0x1233, EXL=1.
  - Second wb_ex with excode=8 leaves EPC unchanged and sets ExcCode=8.
- ERET:
  - eret with wb_ex=0 clears EXL; `epc_out` holds its value.
  - eret with wb_ex=1 leaves EXL=1.
  - MTC0 EPC=0x1234 in a cycle with wb_ex=1 is ignored.
- External and software interrupts, N_EXT_INT=2:
  - ext_int_in=2'b10, IM=0x08, IE=1 → IP=0x08 and `has_int`=1 the next cycle.
  - MTC0 Cause=0x100 → IP0=1.
  - Count write 0xFFFF_FFFF followed by a tick → 0.
